// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter must hold 0..WIDTH.
  function automatic int calc_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/addsub_nbit.sv
// N-bit add/subtract. Subtraction is done as a + ~b + 1.
module addsub_nbit #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);

  always_comb begin
    y = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH shift-add multiplier, unsigned or two's complement,
// one partial product per clock with a start/busy/done handshake.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT,
  parameter int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mreg;
  logic [WIDTH-1:0]   mcand;
  logic               sgn;
  logic [CNT_W-1:0]   cnt;

  logic               last;
  logic               sub;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   mreg_next;

  // The multiplier MSB carries negative weight in signed mode, so the
  // final partial product is subtracted rather than added.
  always_comb begin
    last      = (cnt == LAST_CNT);
    sub       = sgn & last;
    addend    = mreg[0] ? {sgn & mcand[WIDTH-1], mcand} : '0;
    acc_next  = {sgn & sum[WIDTH], sum[WIDTH:1]};
    mreg_next = {sum[0], mreg[WIDTH-1:1]};
  end

  addsub_nbit #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a   (acc),
    .b   (addend),
    .sub (sub),
    .y   (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mreg    <= '0;
      mcand   <= '0;
      sgn     <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= multiplicand;
            mreg  <= multiplier;
            acc   <= '0;
            sgn   <= signed_mode;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc  <= acc_next;
          mreg <= mreg_next;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            product <= {acc_next[WIDTH-1:0], mreg_next};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH=32, plus a 4/8-bit sweep.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] p32;

  logic        st_s, sm_s;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  p4;
  logic [15:0] p8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
    .multiplicand(a32), .multiplier(b32),
    .busy(busy32), .done(done32), .product(p32)
  );

  shift_add_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st_s), .signed_mode(sm_s),
    .multiplicand(a4), .multiplier(b4),
    .busy(busy4), .done(done4), .product(p4)
  );

  shift_add_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st_s), .signed_mode(sm_s),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(p8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] golden(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input bit s);
    logic [63:0] mask, ea, eb, pm;
    mask = (64'd1 << w) - 64'd1;
    ea = a & mask;
    eb = b & mask;
    if (s && ea[w-1]) ea = ea | ~mask;
    if (s && eb[w-1]) eb = eb | ~mask;
    pm = ea * eb;
    return pm & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Called at a sample point (#1 after an edge). Returns at the sample where
  // done is seen. restart_at>0 re-pulses start with other operands mid-run.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input bit sm,
                      input int restart_at, output logic [63:0] p,
                      output int lat, output int busy_n, output int hold_bad);
    logic [63:0] p0;
    p0 = p32;
    a32 = a; b32 = b; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = busy32 ? 1 : 0;
    lat = 0; p = '0; hold_bad = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (n == restart_at) begin
        a32 = 32'd7; b32 = 32'd7; signed_mode = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done32) begin
        lat = n;
        p = p32;
        break;
      end
      if (busy32) busy_n++;
      if (p32 !== p0) hold_bad++;
    end
  endtask

  initial begin
    logic [63:0] p;
    logic [7:0]  r4;
    logic [15:0] r8;
    int lat, bn, hb, lat4, lat8, seen;

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a32 = '0; b32 = '0;
    st_s = 1'b0; sm_s = 1'b0; a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_product", p32, 0);
    rst = 1'b0;

    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, p, lat, bn, hb);
    check("umax_product", p, 64'hFFFF_FFFE_0000_0001);
    check("umax_latency", lat, 32);
    check("umax_busy_cycles", bn, 32);
    @(posedge clk); #1;
    check("done_pulse_clears", done32, 0);
    check("product_holds", p32, 64'hFFFF_FFFE_0000_0001);

    op32(32'hFFFF_FFFD, 32'd5, 1'b1, 0, p, lat, bn, hb);
    check("smixed_signed", p, 64'hFFFF_FFFF_FFFF_FFF1);
    op32(32'hFFFF_FFFD, 32'd5, 1'b0, 0, p, lat, bn, hb);
    check("smixed_unsigned", p, 64'h0000_0004_FFFF_FFF1);
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, 0, p, lat, bn, hb);
    check("signed_minmin", p, 64'h4000_0000_0000_0000);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, p, lat, bn, hb);
    check("signed_m1m1", p, 64'h0000_0000_0000_0001);

    op32(32'd1000, 32'd3, 1'b0, 10, p, lat, bn, hb);
    check("restart_ignored", p, 64'd3000);
    check("restart_latency", lat, 32);
    @(posedge clk); #1;
    check("restart_no_extra_done", {63'd0, done32} | {63'd0, busy32}, 0);

    // Back-to-back: second start issued in the done cycle of the first.
    op32(32'd6, 32'd7, 1'b0, 0, p, lat, bn, hb);
    check("b2b_first", p, 64'd42);
    op32(32'd9, 32'd9, 1'b0, 0, p, lat, bn, hb);
    check("b2b_second", p, 64'd81);
    check("b2b_latency", lat, 32);
    check("b2b_product_held", hb, 0);

    a32 = 32'h0001_2345; b32 = 32'h0000_0777; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy32, 0);
    check("abort_done", done32, 0);
    check("abort_product", p32, 0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    check("abort_no_done", seen, 0);
    op32(32'd7, 32'd6, 1'b0, 0, p, lat, bn, hb);
    check("after_abort_7x6", p, 64'd42);

    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        a4 = 4'h8; b4 = 4'h8; a8 = 8'h80; b8 = 8'h80; sm_s = 1'b1;
      end else if (i == 1) begin
        a4 = 4'hF; b4 = 4'hF; a8 = 8'hFF; b8 = 8'hFF; sm_s = 1'b0;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
        sm_s = i[0];
      end
      st_s = 1'b1;
      @(posedge clk); #1;
      st_s = 1'b0;
      lat4 = 0; lat8 = 0; r4 = '0; r8 = '0;
      for (int n = 1; n <= 12; n++) begin
        @(posedge clk); #1;
        if (done4) begin lat4 = n; r4 = p4; end
        if (done8) begin lat8 = n; r8 = p8; end
      end
      check($sformatf("w4_product_%0d", i), r4, golden(4, 64'(a4), 64'(b4), sm_s));
      check($sformatf("w8_product_%0d", i), r8, golden(8, 64'(a8), 64'(b8), sm_s));
      check($sformatf("w4_latency_%0d", i), lat4, 4);
      check($sformatf("w8_latency_%0d", i), lat8, 8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
